// File: rtl/rv32i_core_multiciclo.sv
// rv32i_core_multiciclo: multicycle RV32I core with request/ready handshakes to IMEM and DMEM.
// Sequencer FETCH->DECODE->EXECUTE->(MEM)->WB, sticky trap on illegal encodings.
module rv32i_core_multiciclo #(
    parameter int          IMEM_AW  = 10,
    parameter int          DMEM_AW  = 10,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               CLK,
    input  logic               RESET_N,
    output logic               IMEM_REQ,
    output logic [IMEM_AW-1:0] IMEM_ADDR,
    input  logic [31:0]        IMEM_RDATA,
    input  logic               IMEM_READY,
    output logic               DMEM_READ,
    output logic               DMEM_WRITE,
    output logic [DMEM_AW-1:0] DMEM_ADDR,
    output logic [31:0]        DMEM_WDATA,
    input  logic [31:0]        DMEM_RDATA,
    input  logic               DMEM_READY,
    output logic               ILLEGAL,
    output logic               RETIRE
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, TRAP} state_t;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    state_t             r_state;
    logic [31:0]        r_pc, r_ir, r_a, r_b, r_imm, r_res;
    logic               r_taken;
    logic [31:0]        r_rf [32];
    logic               r_imem_req, r_dmem_read, r_dmem_write, r_illegal, r_retire;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic [DMEM_AW-1:0] r_dmem_addr;
    logic [31:0]        r_dmem_wdata;

    logic [6:0]  w_op;
    logic [2:0]  w_f3, w_alu_f3;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic        w_legal, w_sub, w_taken, w_we, w_mem;
    logic [31:0] w_imm, w_opa, w_opb, w_alu, w_res, w_pc4, w_next_pc, w_wb;

    assign w_op  = r_ir[6:0];
    assign w_f3  = r_ir[14:12];
    assign w_rd  = r_ir[11:7];
    assign w_rs1 = r_ir[19:15];
    assign w_rs2 = r_ir[24:20];
    assign w_mem = (w_op == OP_LD) || (w_op == OP_ST);

    // Loads/stores are word-only; branch funct3 010/011 are reserved.
    assign w_legal = (w_op == OP_LUI) || (w_op == OP_AUIPC) || (w_op == OP_JAL) ||
                     (w_op == OP_JALR && w_f3 == 3'b000) ||
                     (w_op == OP_BR && w_f3[2:1] != 2'b01) ||
                     (w_mem && w_f3 == 3'b010) ||
                     (w_op == OP_IMM) || (w_op == OP_REG);

    assign w_imm = (w_op == OP_ST) ? {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]} :
                   (w_op == OP_BR) ? {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0} :
                   (w_op == OP_LUI || w_op == OP_AUIPC) ? {r_ir[31:12], 12'b0} :
                   (w_op == OP_JAL) ? {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0} :
                   {{20{r_ir[31]}}, r_ir[31:20]};

    // Only R-type and OP-IMM select an ALU function; everything else adds.
    assign w_opa    = (w_op == OP_AUIPC) ? r_pc : r_a;
    assign w_opb    = (w_op == OP_REG) ? r_b : r_imm;
    assign w_alu_f3 = (w_op == OP_REG || w_op == OP_IMM) ? w_f3 : 3'b000;
    assign w_sub    = (w_op == OP_REG) && r_ir[30];

    always_comb begin
        w_alu = w_opa + w_opb;
        case (w_alu_f3)
            3'b000:  w_alu = w_sub ? w_opa - w_opb : w_opa + w_opb;
            3'b001:  w_alu = w_opa << w_opb[4:0];
            3'b010:  w_alu = {31'b0, $signed(w_opa) < $signed(w_opb)};
            3'b011:  w_alu = {31'b0, w_opa < w_opb};
            3'b100:  w_alu = w_opa ^ w_opb;
            3'b101:  w_alu = r_ir[30] ? $signed(w_opa) >>> w_opb[4:0] : w_opa >> w_opb[4:0];
            3'b110:  w_alu = w_opa | w_opb;
            default: w_alu = w_opa & w_opb;
        endcase
    end

    assign w_res   = (w_op == OP_LUI) ? r_imm : w_alu;
    assign w_taken = (w_f3[2:1] == 2'b00) ? ((r_a == r_b) ^ w_f3[0]) :
                     (w_f3[2:1] == 2'b10) ? (($signed(r_a) < $signed(r_b)) ^ w_f3[0]) :
                     ((r_a < r_b) ^ w_f3[0]);

    assign w_pc4     = r_pc + 32'd4;
    assign w_next_pc = (w_op == OP_JALR) ? {r_res[31:1], 1'b0} :
                       (w_op == OP_JAL || (w_op == OP_BR && r_taken)) ? r_pc + r_imm : w_pc4;
    assign w_wb      = (w_op == OP_JAL || w_op == OP_JALR) ? w_pc4 : r_res;
    assign w_we      = (w_rd != 5'd0) && (w_op != OP_BR) && (w_op != OP_ST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_imm        <= '0;
            r_res        <= '0;
            r_taken      <= 1'b0;
            r_imem_req   <= 1'b0;
            r_imem_addr  <= '0;
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_illegal    <= 1'b0;
            r_retire     <= 1'b0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                FETCH: begin
                    if (r_imem_req && IMEM_READY) begin
                        r_ir       <= IMEM_RDATA;
                        r_imem_req <= 1'b0;
                        r_state    <= DECODE;
                    end else begin
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_pc[IMEM_AW+1:2];
                    end
                end
                DECODE: begin
                    r_a   <= r_rf[w_rs1];
                    r_b   <= r_rf[w_rs2];
                    r_imm <= w_imm;
                    r_state   <= w_legal ? EXECUTE : TRAP;
                    r_illegal <= !w_legal;
                end
                EXECUTE: begin
                    r_res        <= w_res;
                    r_taken      <= w_taken;
                    r_dmem_read  <= w_op == OP_LD;
                    r_dmem_write <= w_op == OP_ST;
                    r_dmem_addr  <= w_res[DMEM_AW+1:2];
                    r_dmem_wdata <= r_b;
                    r_retire     <= !w_mem;
                    r_state      <= w_mem ? MEM : WB;
                end
                MEM: begin
                    if (DMEM_READY) begin
                        if (r_dmem_read) r_res <= DMEM_RDATA;
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        r_retire     <= 1'b1;
                        r_state      <= WB;
                    end
                end
                WB: begin
                    if (w_we) r_rf[w_rd] <= w_wb;
                    r_pc        <= w_next_pc;
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= w_next_pc[IMEM_AW+1:2];
                    r_state     <= FETCH;
                end
                default: r_state <= TRAP;
            endcase
        end
    end

    assign IMEM_REQ   = r_imem_req;
    assign IMEM_ADDR  = r_imem_addr;
    assign DMEM_READ  = r_dmem_read;
    assign DMEM_WRITE = r_dmem_write;
    assign DMEM_ADDR  = r_dmem_addr;
    assign DMEM_WDATA = r_dmem_wdata;
    assign ILLEGAL    = r_illegal;
    assign RETIRE     = r_retire;
endmodule

// File: tb/tb_rv32i_core_multiciclo.sv
// tb_rv32i_core_multiciclo: directed programs against hand-computed PCs, registers and handshake timing.
module tb_rv32i_core_multiciclo;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IMEM_REQ, IMEM_READY, DMEM_READ, DMEM_WRITE, DMEM_READY, ILLEGAL, RETIRE;
    logic [9:0]  IMEM_ADDR, DMEM_ADDR;
    logic [31:0] IMEM_RDATA, DMEM_WDATA, DMEM_RDATA;
    logic [31:0] imem [128];
    logic [31:0] dmem [64];
    logic        imem_en = 1'b1;
    int          dwait = 0;
    int          dcnt;
    int          n_checks = 0, n_errors = 0;
    int          wr_cycles = 0, wr_bad = 0, viol = 0, req_cycles = 0;
    int          req_mark;

    rv32i_core_multiciclo #(.IMEM_AW(10), .DMEM_AW(10), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA), .IMEM_READY(IMEM_READY),
        .DMEM_READ(DMEM_READ), .DMEM_WRITE(DMEM_WRITE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA), .DMEM_READY(DMEM_READY),
        .ILLEGAL(ILLEGAL), .RETIRE(RETIRE)
    );

    always #5 CLK = ~CLK;

    assign IMEM_READY = imem_en;
    assign IMEM_RDATA = imem[IMEM_ADDR[6:0]];
    assign DMEM_RDATA = dmem[DMEM_ADDR[5:0]];
    assign DMEM_READY = (DMEM_READ || DMEM_WRITE) && dcnt == dwait;

    // DMEM answers after dwait stall cycles
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) dcnt <= 0;
        else if (DMEM_READ || DMEM_WRITE) begin
            if (DMEM_READY) begin
                if (DMEM_WRITE) dmem[DMEM_ADDR[5:0]] <= DMEM_WDATA;
                dcnt <= 0;
            end else dcnt <= dcnt + 1;
        end
    end

    always @(negedge CLK) begin
        if (DMEM_WRITE) begin
            wr_cycles++;
            if (DMEM_ADDR != 10'd2 || DMEM_WDATA != 32'd2) wr_bad++;
        end
        if ((DMEM_READ && DMEM_WRITE) || (IMEM_REQ && (DMEM_READ || DMEM_WRITE))) viol++;
        if (IMEM_REQ) req_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input int exp_n, input logic [31:0] exp_pc);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!RETIRE && n < 100);
        @(posedge CLK);
        #1;
        check({tag, "_cycles"}, 32'(n), 32'(exp_n));
        check({tag, "_pc"}, dut.r_pc, exp_pc);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = 32'h0;
        imem[0] = 32'h00500093;
        imem[1] = 32'hFFD00113;
        imem[2] = 32'h002081B3;
        imem[3] = 32'h00108033;
        imem[4] = 32'h00302423;
        imem[5] = 32'h00802203;
        #12;
        check("rst_imem_req", 32'(IMEM_REQ), 32'd0);
        check("rst_imem_addr", 32'(IMEM_ADDR), 32'd0);
        check("rst_dmem_rw", {30'd0, DMEM_READ, DMEM_WRITE}, 32'd0);
        check("rst_flags", {30'd0, ILLEGAL, RETIRE}, 32'd0);
        check("rst_pc", dut.r_pc, 32'h0);
        @(negedge CLK) RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        check("rel_imem_req", 32'(IMEM_REQ), 32'd1);
        check("rel_imem_addr", 32'(IMEM_ADDR), 32'd0);
        step("addi1", 4, 32'h04);
        step("addi2", 4, 32'h08);
        step("add3", 4, 32'h0C);
        step("add0", 4, 32'h10);
        check("x1", dut.r_rf[1], 32'd5);
        check("x2", dut.r_rf[2], 32'hFFFF_FFFD);
        check("x3", dut.r_rf[3], 32'd2);
        check("x0", dut.r_rf[0], 32'd0);
        dwait = 3;
        step("sw", 8, 32'h14);
        check("sw_hold_cycles", 32'(wr_cycles), 32'd4);
        check("sw_addr_data", 32'(wr_bad), 32'd0);
        check("sw_mem", dmem[2], 32'd2);
        step("lw", 8, 32'h18);
        check("x4", dut.r_rf[4], 32'd2);
        imem_en = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("stall_req", 32'(IMEM_REQ), 32'd1);
        check("stall_addr", 32'(IMEM_ADDR), 32'd6);
        #2 RESET_N = 1'b0;
        #1;
        check("midrst_req", 32'(IMEM_REQ), 32'd0);
        check("midrst_pc", dut.r_pc, 32'h0);
        check("midrst_x4", dut.r_rf[4], 32'd0);
        for (int i = 0; i < 128; i++) imem[i] = 32'h0;
        imem[0]  = 32'h00500093;
        imem[1]  = 32'h00108463;
        imem[2]  = 32'h00100313;
        imem[3]  = 32'h00109463;
        imem[4]  = 32'h0100006F;
        imem[5]  = 32'h10100393;
        imem[6]  = 32'h00038467;
        imem[8]  = 32'hFF5FF2EF;
        imem[64] = 32'h0000007F;
        imem_en = 1'b1;
        dwait = 0;
        @(negedge CLK) RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        check("restart_req", 32'(IMEM_REQ), 32'd1);
        step("addi_b", 4, 32'h04);
        step("beq", 4, 32'h0C);
        step("bne", 4, 32'h10);
        step("jal_fwd", 4, 32'h20);
        step("jal_back", 4, 32'h14);
        check("x5", dut.r_rf[5], 32'h24);
        step("addi_odd", 4, 32'h18);
        step("jalr", 4, 32'h100);
        check("x8", dut.r_rf[8], 32'h1C);
        check("x6_skipped", dut.r_rf[6], 32'd0);
        check("x0_jal", dut.r_rf[0], 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        check("illegal_set", 32'(ILLEGAL), 32'd1);
        req_mark = req_cycles;
        repeat (20) @(posedge CLK);
        #1;
        check("trap_no_req", 32'(req_cycles - req_mark), 32'd0);
        check("trap_pc", dut.r_pc, 32'h100);
        check("trap_sticky", 32'(ILLEGAL), 32'd1);
        check("no_overlap", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rv32i_core_multiciclo.md
Name: rv32i_core_multiciclo

Overview:
- Parametrised multicycle RV32I core; the successor to the single-cycle CORE.
- Runs a finite-state sequencer (fetch/decode/execute/memory/writeback) so that instruction and data memories with variable latency are handled through request/ready handshakes.
- Adds JAL/JALR, BNE/BLT/BGE and an illegal-opcode trap.
- Contains its own 32x32 register file and ALU, and connects to IMEM (ROM) and DMEM (RAM) at top level.

Parameters:
- IMEM_AW, 10, IMEM word-address width.
- DMEM_AW, 10, DMEM word-address width.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- IMEM_REQ  out  1  instruction fetch request.
- IMEM_ADDR  out  IMEM_AW  word address = PC[IMEM_AW+1:2].
- IMEM_RDATA  in  32  instruction word.
- IMEM_READY  in  1  IMEM_RDATA valid this cycle.
- DMEM_READ  out  1  load request.
- DMEM_WRITE  out  1  store request.
- DMEM_ADDR  out  DMEM_AW  word address = ALU result[DMEM_AW+1:2].
- DMEM_WDATA  out  32  store data (rs2).
- DMEM_RDATA  in  32  load data.
- DMEM_READY  in  1  access complete this cycle.
- ILLEGAL  out  1  sticky trap flag.
- RETIRE  out  1  one-cycle pulse per retired instruction.

Behaviour:
- Reset (async):
  - PC=RESET_PC; state=FETCH; all 32 registers = 0.
  - IMEM_REQ, DMEM_READ, DMEM_WRITE, ILLEGAL, RETIRE = 0.
  - IMEM_ADDR, DMEM_ADDR, DMEM_WDATA = 0.
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
- FETCH:
  - IMEM_REQ=1 and IMEM_ADDR held stable until IMEM_READY.
  - On IMEM_READY: latch IR, go to DECODE.
- DECODE (1 cycle):
  - Read rs1/rs2 into A/B; generate the immediate (I/S/B/U/J).
  - Unknown opcode, or an unsupported funct3 for a known opcode: go to TRAP.
- EXECUTE (1 cycle):
  - ALU ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - R-type and OP-IMM use funct7[5] and funct3; shift amount is B[4:0].
  - LUI result = imm. AUIPC result = PC+imm.
  - Branch taken compare: BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - Next state: loads/stores go to MEM; all others go to WB.
- MEM:
  - DMEM_READ or DMEM_WRITE asserted, with address and data held, until DMEM_READY.
  - Then: store goes to WB (no register write); load latches DMEM_RDATA and goes to WB.
  - Word access only; address bits [1:0] are ignored.
- WB (1 cycle):
  - Register write if rd!=0. x0 always reads 0, and writes to x0 are discarded.
  - PC update:
    - taken branch: PC+immB
    - JAL: PC+immJ
    - JALR: (rs1+immI)&~1
    - otherwise: PC+4
  - JAL/JALR write the old PC+4 to rd.
  - RETIRE=1 for this cycle only. Go to FETCH.
- TRAP:
  - ILLEGAL=1; the core stays in TRAP and PC is frozen.
  - No memory requests are issued. Only reset exits TRAP.
- Latency with zero-wait memories:
  - ALU/branch/jump: 4 cycles.
  - Load/store: 5 cycles.
  - Each memory wait cycle adds 1.
- Arithmetic:
  - 32-bit wrap-around; no overflow detection.
  - PC wraps modulo 2^32; IMEM_ADDR truncates the high bits.
- Register-file read and write timing:
  - Reads are combinational and sampled in DECODE.
  - The write in WB lands at the end of the cycle, so the next instruction sees it.
- Handshake rules:
  - READY while the corresponding request is deasserted is ignored.
  - DMEM_READ and DMEM_WRITE are never both 1.
  - IMEM_REQ and any DMEM request are never asserted together.
- Reset asserted mid-handshake: requests drop immediately (async) and the partial access is discarded.

Test Plan:
- Reset: hold RESET_N=0 with IMEM_READY=1 -> IMEM_REQ=0 and IMEM_ADDR=0. On release, IMEM_REQ=1 at the first edge with address 0.
- ADDI/ADD sequence `addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; add x0,x1,x1`, zero-wait:
  - x3=2 and x0=0.
  - RETIRE pulses every 4 cycles.
  - After 4 instructions, PC=16.
- Store/load with DMEM_READY delayed 3 cycles: `sw x3,8(x0); lw x4,8(x0)`:
  - DMEM_ADDR=2 and DMEM_WDATA=2, held stable for 4 cycles.
  - x4=2.
  - Each instruction takes 8 cycles.
- Branch/jump:
  - `beq x1,x1,+8` -> PC advances by 8.
  - `bne x1,x1,+8` -> PC advances by 4.
  - `jal x5,-12` at PC=0x20 -> PC=0x14 and x5=0x24.
  - `jalr` with an odd target clears bit 0.
- Illegal opcode 32'h0000007F -> ILLEGAL=1 after DECODE. No further IMEM_REQ, and PC is unchanged after 20 cycles.
- Reset mid-fetch: assert RESET_N=0 while IMEM_REQ=1 with IMEM_READY low -> IMEM_REQ=0 immediately and PC=RESET_PC. The run restarts cleanly.
